// File: rtl/simple_axi_pkg.sv
// Shared definitions for the simple_axi internal bus: op codes, response codes
// and the arbiter state encoding.
package simple_axi_pkg;

  localparam logic [1:0] RW_NOP   = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    A_IDLE   = 3'd0,
    A_ISSUE  = 3'd1,
    A_BUSY   = 3'd2,
    A_DONE   = 3'd3,
    A_REJECT = 3'd4
  } arb_state_t;

  // Next index after idx in a ring of n slots.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/simple_axi_arbiter_if.sv
// Bundle of the requester-side and master-side signals of simple_axi_arbiter.
// Signal directions are named from the arbiter's point of view.
interface simple_axi_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic [2*NUM_REQ-1:0]          i_req_rw;
  logic [ADDR_WIDTH*NUM_REQ-1:0] i_req_addr;
  logic [DATA_WIDTH*NUM_REQ-1:0] i_req_wdata;
  logic [NUM_REQ-1:0]            o_req_wait;
  logic [NUM_REQ-1:0]            o_req_done;
  logic [DATA_WIDTH-1:0]         o_req_rdata;
  logic                          o_req_error;
  logic                          o_req_invalid;
  logic [$clog2(NUM_REQ)-1:0]    o_grant;

  logic [ADDR_WIDTH-1:0]         o_m_addr;
  logic [DATA_WIDTH-1:0]         o_m_wdata;
  logic [1:0]                    o_m_rw;
  logic                          o_m_clear_done;
  logic [DATA_WIDTH-1:0]         i_m_rdata;
  logic                          i_m_wait;
  logic                          i_m_done;
  logic                          i_m_error;
  logic                          i_m_invalid;

  // Arbiter side: owns the requester responses and drives the master port.
  modport master (
    input  i_req_rw, i_req_addr, i_req_wdata,
    output o_req_wait, o_req_done, o_req_rdata, o_req_error, o_req_invalid, o_grant,
    output o_m_addr, o_m_wdata, o_m_rw, o_m_clear_done,
    input  i_m_rdata, i_m_wait, i_m_done, i_m_error, i_m_invalid
  );

  // Environment side: requesters plus the simple_axi_master behind the arbiter.
  modport slave (
    output i_req_rw, i_req_addr, i_req_wdata,
    input  o_req_wait, o_req_done, o_req_rdata, o_req_error, o_req_invalid, o_grant,
    input  o_m_addr, o_m_wdata, o_m_rw, o_m_clear_done,
    output i_m_rdata, i_m_wait, i_m_done, i_m_error, i_m_invalid
  );

endinterface

// File: rtl/simple_axi_arbiter_rr_pick.sv
// Combinational round-robin select: first asserted request at or after the
// pointer, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int               slot;
  logic [IDX_W-1:0] cand;

  // Scan from the pointer; a wrap by subtraction keeps non-power-of-two sizes correct.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    slot    = 0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = int'(i_ptr) + i;
      if (slot >= NUM_REQ) begin
        slot = slot - NUM_REQ;
      end
      cand = IDX_W'(slot);
      if (!o_valid && i_req[cand]) begin
        o_valid = 1'b1;
        o_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/simple_axi_arbiter.sv
// Round-robin arbiter sharing one simple_axi_master port between NUM_REQ
// requesters; each grant runs issue -> wait -> capture -> clear-done.
module simple_axi_arbiter
  import simple_axi_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  simple_axi_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t state;
  arb_state_t state_nxt;

  logic [1:0]            req_rw    [NUM_REQ];
  logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]    req_pend;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;

  logic [IDX_W-1:0]      grant;
  logic [IDX_W-1:0]      rr_ptr;
  logic [1:0]            gnt_rw;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  error_q;
  logic                  invalid_q;
  logic [NUM_REQ-1:0]    done_q;

  logic [1:0]            m_rw;
  logic                  m_clear_done;

  // A requester still showing its op during its own done pulse is not re-granted.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_rw[g]    = bus.i_req_rw[2*g +: 2];
    assign req_addr[g]  = bus.i_req_addr[ADDR_WIDTH*g +: ADDR_WIDTH];
    assign req_wdata[g] = bus.i_req_wdata[DATA_WIDTH*g +: DATA_WIDTH];
    assign req_pend[g]  = (req_rw[g] != RW_NOP) && !done_q[g];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (req_pend),
    .i_ptr   (rr_ptr),
    .o_idx   (pick_idx),
    .o_valid (pick_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= A_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = A_IDLE;
    case (state)
      A_IDLE: begin
        if (pick_valid) begin
          state_nxt = (req_rw[pick_idx] == RW_RSVD) ? A_REJECT : A_ISSUE;
        end
      end
      A_ISSUE:  state_nxt = A_BUSY;
      A_BUSY:   state_nxt = bus.i_m_done ? A_DONE : A_BUSY;
      A_DONE:   state_nxt = A_IDLE;
      A_REJECT: state_nxt = A_IDLE;
      default:  state_nxt = A_IDLE;
    endcase
  end

  always_comb begin
    m_rw         = RW_NOP;
    m_clear_done = 1'b0;
    case (state)
      A_ISSUE: m_rw         = gnt_rw;
      A_DONE:  m_clear_done = 1'b1;
      default: ;
    endcase
  end

  // Status from the master is only valid in its first done cycle, hence the capture in A_BUSY.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant     <= '0;
      rr_ptr    <= '0;
      gnt_rw    <= RW_NOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      invalid_q <= 1'b0;
      done_q    <= '0;
    end else begin
      done_q <= '0;
      case (state)
        A_IDLE: begin
          if (pick_valid) begin
            grant   <= pick_idx;
            gnt_rw  <= req_rw[pick_idx];
            addr_q  <= req_addr[pick_idx];
            wdata_q <= req_wdata[pick_idx];
          end
        end
        A_BUSY: begin
          if (bus.i_m_done) begin
            error_q   <= bus.i_m_error;
            invalid_q <= bus.i_m_invalid;
          end
        end
        A_DONE: begin
          rdata_q       <= bus.i_m_rdata;
          done_q[grant] <= 1'b1;
          rr_ptr        <= IDX_W'(rr_wrap(int'(grant), NUM_REQ));
        end
        A_REJECT: begin
          error_q       <= 1'b1;
          invalid_q     <= 1'b1;
          done_q[grant] <= 1'b1;
          rr_ptr        <= IDX_W'(rr_wrap(int'(grant), NUM_REQ));
        end
        default: ;
      endcase
    end
  end

  assign bus.o_req_wait     = req_pend;
  assign bus.o_req_done     = done_q;
  assign bus.o_req_rdata    = rdata_q;
  assign bus.o_req_error    = error_q;
  assign bus.o_req_invalid  = invalid_q;
  assign bus.o_grant        = grant;
  assign bus.o_m_addr       = addr_q;
  assign bus.o_m_wdata      = wdata_q;
  assign bus.o_m_rw         = m_rw;
  assign bus.o_m_clear_done = m_clear_done;

endmodule

// File: tb/tb_simple_axi_arbiter.sv
// Directed bench for simple_axi_arbiter: a behavioural simple_axi_master model
// behind the arbiter and a scoreboard of expected requester completions.
module tb_simple_axi_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] rdata;
    logic        err;
    logic        inv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  simple_axi_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  simple_axi_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  exp_t sb [$];
  exp_t e;

  logic [1:0]      rw_cmd [NR];
  int              target [NR];
  int              served [NR];
  logic [2*NR-1:0] req_rw_vec;

  logic [31:0] mem [64];
  int          slave_lat = 1;
  int          issue_count = 0;
  int          overlap = 0;
  logic        m_busy;
  int          m_cnt;
  logic [1:0]  m_rw;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic apply_stimulus(input int k, input logic [1:0] rw, input logic [31:0] addr,
                                input logic [31:0] wdata, input int count);
    rw_cmd[k] = rw;
    bus.i_req_addr[32*k +: 32]  = addr;
    bus.i_req_wdata[32*k +: 32] = wdata;
    target[k] = served[k] + count;
  endtask

  task automatic push_exp(input int idx, input logic [31:0] rdata, input logic err, input logic inv);
    exp_t x;
    x.idx   = 2'(idx);
    x.rdata = rdata;
    x.err   = err;
    x.inv   = inv;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("drain", 64'(sb.size()), 64'h0);
    @(negedge clk);
  endtask

  // A requester's op stays visible until it has been served the requested number of times.
  always_comb begin
    req_rw_vec = '0;
    for (int k = 0; k < NR; k++) begin
      req_rw_vec[2*k +: 2] = (served[k] < target[k]) ? rw_cmd[k] : 2'b00;
    end
  end
  assign bus.i_req_rw = req_rw_vec;

  // Master model: addresses 0xE... answer SLVERR, 0xF... DECERR, others OKAY.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy          <= 1'b0;
      m_cnt           <= 0;
      m_rw            <= 2'b00;
      m_addr          <= '0;
      m_wdata         <= '0;
      bus.i_m_wait    <= 1'b0;
      bus.i_m_done    <= 1'b0;
      bus.i_m_error   <= 1'b0;
      bus.i_m_invalid <= 1'b0;
      bus.i_m_rdata   <= '0;
    end else begin
      bus.i_m_error   <= 1'b0;
      bus.i_m_invalid <= 1'b0;
      if (bus.o_m_clear_done) begin
        bus.i_m_done <= 1'b0;
      end
      if (bus.o_m_rw != 2'b00) begin
        if (m_busy || bus.i_m_done) begin
          overlap = overlap + 1;
        end
        issue_count = issue_count + 1;
        m_busy       <= 1'b1;
        m_cnt        <= slave_lat;
        m_rw         <= bus.o_m_rw;
        m_addr       <= bus.o_m_addr;
        m_wdata      <= bus.o_m_wdata;
        bus.i_m_wait <= 1'b1;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy          <= 1'b0;
          bus.i_m_wait    <= 1'b0;
          bus.i_m_done    <= 1'b1;
          bus.i_m_error   <= (m_addr[31:28] == 4'hE) || (m_addr[31:28] == 4'hF);
          bus.i_m_invalid <= (m_addr[31:28] == 4'hF);
          bus.i_m_rdata   <= '0;
          if (m_addr[31:28] < 4'hE) begin
            if (m_rw == 2'b10) begin
              bus.i_m_rdata <= mem[m_addr[7:2]];
            end else begin
              mem[m_addr[7:2]] <= m_wdata;
            end
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Scoreboard: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n && bus.o_req_done != '0) begin
      if (sb.size() == 0) begin
        check_output("spurious_done", 64'(bus.o_req_done), 64'h0);
      end else begin
        e = sb.pop_front();
        check_output("done_vec", 64'(bus.o_req_done), 64'(4'b0001 << e.idx));
        check_output("grant",    64'(bus.o_grant),    64'(e.idx));
        check_output("rdata",    64'(bus.o_req_rdata), 64'(e.rdata));
        check_output("error",    64'(bus.o_req_error), 64'(e.err));
        check_output("invalid",  64'(bus.o_req_invalid), 64'(e.inv));
      end
      for (int k = 0; k < NR; k++) begin
        if (bus.o_req_done[k]) begin
          served[k] = served[k] + 1;
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check_output({tag, "_grant"},   64'(bus.o_grant), 64'h0);
    check_output({tag, "_m_rw"},    64'(bus.o_m_rw), 64'h0);
    check_output({tag, "_clear"},   64'(bus.o_m_clear_done), 64'h0);
    check_output({tag, "_done"},    64'(bus.o_req_done), 64'h0);
    check_output({tag, "_rdata"},   64'(bus.o_req_rdata), 64'h0);
    check_output({tag, "_error"},   64'(bus.o_req_error), 64'h0);
    check_output({tag, "_invalid"}, 64'(bus.o_req_invalid), 64'h0);
    check_output({tag, "_m_addr"},  64'(bus.o_m_addr), 64'h0);
    check_output({tag, "_m_wdata"}, 64'(bus.o_m_wdata), 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hC0DE_0000 + 32'(i);
    end
    mem[0] = 32'hDEAD_BEEF;
    for (int k = 0; k < NR; k++) begin
      rw_cmd[k] = 2'b00;
      target[k] = 0;
      served[k] = 0;
    end
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;

    $display("[TB] reset values");
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    check_output("reset_wait", 64'(bus.o_req_wait), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single read by requester 2");
    push_exp(2, 32'hDEAD_BEEF, 1'b0, 1'b0);
    apply_stimulus(2, 2'b10, 32'h0000_1000, 32'h0, 1);
    #1;
    check_output("read_wait", 64'(bus.o_req_wait), 64'h4);
    @(negedge clk);
    check_output("read_issue_rw",   64'(bus.o_m_rw), 64'h2);
    check_output("read_issue_addr", 64'(bus.o_m_addr), 64'h1000);
    check_output("read_issue_gnt",  64'(bus.o_grant), 64'h2);
    wait_drain(40);
    check_output("read_issues", 64'(issue_count), 64'd1);
    check_output("read_wait_clr", 64'(bus.o_req_wait), 64'h0);

    $display("[TB] simultaneous requests from 0 and 3");
    push_exp(3, 32'h0, 1'b0, 1'b0);
    apply_stimulus(3, 2'b01, 32'h0000_0010, 32'h0BAD_F00D, 1);
    wait_drain(40);
    push_exp(0, 32'h0, 1'b0, 1'b0);
    push_exp(3, 32'h1111_2222, 1'b0, 1'b0);
    apply_stimulus(0, 2'b01, 32'h0000_0010, 32'h1111_2222, 1);
    apply_stimulus(3, 2'b10, 32'h0000_0010, 32'h0, 1);
    wait_drain(60);
    check_output("simul_issues", 64'(issue_count), 64'd4);

    $display("[TB] fairness among 0,1,2");
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 32'hC0DE_0008, 1'b0, 1'b0);
      push_exp(1, 32'hC0DE_0009, 1'b0, 1'b0);
      push_exp(2, 32'hC0DE_000A, 1'b0, 1'b0);
    end
    apply_stimulus(0, 2'b10, 32'h0000_0020, 32'h0, 2);
    apply_stimulus(1, 2'b10, 32'h0000_0024, 32'h0, 2);
    apply_stimulus(2, 2'b10, 32'h0000_0028, 32'h0, 2);
    wait_drain(150);
    check_output("fair_issues", 64'(issue_count), 64'd10);

    $display("[TB] error status");
    push_exp(3, 32'h0, 1'b1, 1'b0);
    apply_stimulus(3, 2'b01, 32'hE000_0000, 32'h5555_5555, 1);
    wait_drain(40);
    push_exp(0, 32'h0, 1'b1, 1'b1);
    apply_stimulus(0, 2'b10, 32'hF000_0004, 32'h0, 1);
    wait_drain(40);
    push_exp(1, 32'hC0DE_0009, 1'b0, 1'b0);
    apply_stimulus(1, 2'b10, 32'h0000_0024, 32'h0, 1);
    wait_drain(40);
    check_output("err_issues", 64'(issue_count), 64'd13);

    $display("[TB] reserved op");
    push_exp(1, 32'hC0DE_0009, 1'b1, 1'b1);
    apply_stimulus(1, 2'b11, 32'h0000_0030, 32'h0, 1);
    @(negedge clk);
    check_output("rsvd_done_early", 64'(bus.o_req_done), 64'h0);
    check_output("rsvd_m_rw_1",     64'(bus.o_m_rw), 64'h0);
    @(negedge clk);
    check_output("rsvd_done",   64'(bus.o_req_done), 64'h2);
    check_output("rsvd_m_rw_2", 64'(bus.o_m_rw), 64'h0);
    wait_drain(20);
    check_output("rsvd_issues", 64'(issue_count), 64'd13);

    $display("[TB] reset during a transfer");
    slave_lat = 8;
    apply_stimulus(2, 2'b10, 32'h0000_0028, 32'h0, 1);
    repeat (3) @(negedge clk);
    check_output("mid_issues", 64'(issue_count), 64'd14);
    check_output("mid_busy_rw", 64'(bus.o_m_rw), 64'h0);
    rst_n = 1'b0;
    target[2] = served[2];
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    check_output("midrst_hold_done", 64'(bus.o_req_done), 64'h0);
    rst_n = 1'b1;
    slave_lat = 1;
    @(negedge clk);
    push_exp(0, 32'hC0DE_0009, 1'b0, 1'b0);
    apply_stimulus(0, 2'b10, 32'h0000_0024, 32'h0, 1);
    wait_drain(40);
    check_output("post_rst_issues", 64'(issue_count), 64'd15);
    check_output("overlap", 64'(overlap), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
